uc_irq: RTL and testbench

Parametrised successor to the CPU control unit. It decodes the full 16-bit instruction set, including arithmetic, immediate load, jumps, stack, port I/O and data memory. It adds a registered interrupt controller with N_IRQ edge-triggered channels, masking, fixed priority, a two-cycle entry sequence (push return PC, load vector) and a RETI return. It sits between instruction memory and the datapath and drives every datapath select and write enable.

---
 rtl/uc_irq.sv | 166 ++++++++++++++++
 tb/tb_uc_irq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_irq.sv
// uc_irq: instruction decoder for the 16-bit CPU, plus an edge-triggered,
// maskable, fixed-priority interrupt controller. On a take, the current
// instruction is suppressed and its PC is pushed, so RETI re-runs it.
module uc_irq #(
  parameter int              N_IRQ    = 4,
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] VEC_BASE = 10'h3F0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      opcode,
  input  logic             z,
  input  logic [N_IRQ-1:0] irq,
  output logic             s_inc,
  output logic             we3,
  output logic             wez,
  output logic             s_pila,
  output logic             push,
  output logic             pop,
  output logic             we4,
  output logic             s_out,
  output logic             we5,
  output logic [1:0]       s_port,
  output logic [1:0]       s_inm,
  output logic [2:0]       op_alu,
  output logic             s_vec,
  output logic             s_ret,
  output logic [PC_W-1:0]  vec_addr,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             int_active
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic {RUN, VEC} state_t;

  typedef struct packed {
    logic       s_inc, we3, wez, s_pila, push, pop, we4, s_out, we5;
    logic [1:0] s_port, s_inm;
    logic [2:0] op_alu;
    logic       s_vec, s_ret;
  } ctrl_t;

  state_t          state;
  logic            ie;
  logic [N_IRQ-1:0] mask, pending, irq_prev;
  logic [PC_W-1:0] vec_reg;

  ctrl_t           dec, ctrl;
  logic            is_reti, is_ei, is_imask;
  logic            take;
  logic [ID_W-1:0] take_id;
  logic [N_IRQ-1:0] cand, ack_vec;
  logic [PC_W-1:0] vec_take;

  // Bits that no instruction field reads.
  logic unused_op;
  assign unused_op = &{1'b0, opcode[9:6]};

  // Plain instruction decode, independent of interrupt state.
  always_comb begin
    dec       = '0;
    dec.s_inc = 1'b1;
    is_reti   = 1'b0;
    is_ei     = 1'b0;
    is_imask  = 1'b0;
    casez (opcode[15:10])
      6'b0?????: begin dec.op_alu = opcode[14:12]; dec.we3 = 1'b1; dec.wez = 1'b1; end
      6'b100000: begin dec.we3 = 1'b1; dec.s_inm = 2'b01; end
      6'b100001: dec.s_inc = 1'b0;
      6'b100010: dec.s_inc = ~z;
      6'b100011: dec.s_inc = z;
      6'b100100: dec.push = 1'b1;
      6'b100101: begin dec.pop = 1'b1; dec.s_pila = 1'b1; end
      6'b100110: begin dec.we3 = 1'b1; dec.s_inm = 2'b11; dec.s_port = opcode[5:4]; end
      6'b100111: dec.we5 = 1'b1;
      6'b101000: begin dec.we5 = 1'b1; dec.s_out = 1'b1; end
      6'b101001: begin dec.pop = 1'b1; dec.s_ret = 1'b1; dec.s_inc = 1'b0; is_reti = 1'b1; end
      6'b101010: is_ei = 1'b1;
      6'b101011: is_imask = 1'b1;
      6'b111000: begin dec.we3 = 1'b1; dec.s_inm = 2'b10; end
      6'b1111??: dec.we4 = 1'b1;
      default:   ;
    endcase
  end

  // Lowest-index eligible channel wins; take only from idle RUN with ie set.
  always_comb begin
    cand    = pending & mask;
    take_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (cand[i]) take_id = ID_W'(i);
    take     = reset && (state == RUN) && ie && !int_active && (|cand);
    ack_vec  = take ? (N_IRQ'(1) << take_id) : '0;
    vec_take = VEC_BASE + PC_W'(take_id);
  end

  // Output mux: reset forces NOP, entry cycles override the decoded opcode.
  always_comb begin
    ctrl       = '0;
    ctrl.s_inc = 1'b1;
    vec_addr   = '0;
    if (!reset) begin
      ctrl = ctrl;
    end else if (state == VEC) begin
      ctrl.s_inc = 1'b0;
      ctrl.s_vec = 1'b1;
      vec_addr   = vec_reg;
    end else if (take) begin
      ctrl.s_inc = 1'b0;
      ctrl.push  = 1'b1;
      vec_addr   = vec_take;
    end else begin
      ctrl = dec;
    end
  end

  assign s_inc   = ctrl.s_inc;
  assign we3     = ctrl.we3;
  assign wez     = ctrl.wez;
  assign s_pila  = ctrl.s_pila;
  assign push    = ctrl.push;
  assign pop     = ctrl.pop;
  assign we4     = ctrl.we4;
  assign s_out   = ctrl.s_out;
  assign we5     = ctrl.we5;
  assign s_port  = ctrl.s_port;
  assign s_inm   = ctrl.s_inm;
  assign op_alu  = ctrl.op_alu;
  assign s_vec   = ctrl.s_vec;
  assign s_ret   = ctrl.s_ret;
  assign irq_ack = ack_vec;

  // Entry FSM plus interrupt state; new edges beat a same-cycle ack clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      ie         <= 1'b0;
      mask       <= '1;
      pending    <= '0;
      int_active <= 1'b0;
      irq_prev   <= '0;
      vec_reg    <= '0;
    end else begin
      irq_prev <= irq;
      pending  <= (pending & ~ack_vec) | (irq & ~irq_prev);
      case (state)
        VEC: state <= RUN;
        default: begin
          if (take) begin
            state      <= VEC;
            int_active <= 1'b1;
            ie         <= 1'b0;
            vec_reg    <= vec_take;
          end else begin
            if (is_reti) begin
              int_active <= 1'b0;
              ie         <= 1'b1;
            end
            if (is_ei)    ie   <= opcode[0];
            if (is_imask) mask <= opcode[N_IRQ-1:0];
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uc_irq.sv
// Scoreboard bench for uc_irq: the stimulus process pushes the expected
// outputs of each cycle from a behavioural model; a negedge monitor pops
// and compares against the DUT.
module tb_uc_irq;
  localparam int             N  = 4;
  localparam int             PW = 10;
  localparam logic [PW-1:0]  VB = 10'h3F0;

  logic          clk, reset, z;
  logic [15:0]   opcode;
  logic [N-1:0]  irq;
  logic          s_inc, we3, wez, s_pila, push, pop, we4, s_out, we5;
  logic [1:0]    s_port, s_inm;
  logic [2:0]    op_alu;
  logic          s_vec, s_ret, int_active;
  logic [PW-1:0] vec_addr;
  logic [N-1:0]  irq_ack;

  uc_irq #(.N_IRQ(N), .PC_W(PW), .VEC_BASE(VB)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .irq(irq),
    .s_inc(s_inc), .we3(we3), .wez(wez), .s_pila(s_pila), .push(push),
    .pop(pop), .we4(we4), .s_out(s_out), .we5(we5), .s_port(s_port),
    .s_inm(s_inm), .op_alu(op_alu), .s_vec(s_vec), .s_ret(s_ret),
    .vec_addr(vec_addr), .irq_ack(irq_ack), .int_active(int_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          s_inc, we3, wez, s_pila, push, pop, we4, s_out, we5;
    logic [1:0]    s_port, s_inm;
    logic [2:0]    op_alu;
    logic          s_vec, s_ret;
    logic [PW-1:0] vec_addr;
    logic [N-1:0]  irq_ack;
    logic          int_active;
  } out_t;

  out_t act;
  assign act = {s_inc, we3, wez, s_pila, push, pop, we4, s_out, we5,
                s_port, s_inm, op_alu, s_vec, s_ret, vec_addr, irq_ack, int_active};

  out_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  // Reference model state, described by the controller's rules.
  bit          m_ie, m_active, m_invec;
  bit [N-1:0]  m_mask, m_pend, m_prev;
  bit [PW-1:0] m_vec;

  function automatic void model_reset();
    m_ie = 0; m_active = 0; m_invec = 0;
    m_mask = '1; m_pend = '0; m_prev = '0; m_vec = '0;
  endfunction

  function automatic out_t nop();
    out_t o = '0;
    o.s_inc = 1'b1;
    return o;
  endfunction

  // Instruction table.
  function automatic out_t decode_op(logic [15:0] op, logic zz);
    out_t     o = nop();
    bit [5:0] p = op[15:10];
    if (!p[5]) begin
      o.op_alu = op[14:12]; o.we3 = 1; o.wez = 1;
    end else if (p[5:2] == 4'b1111) begin
      o.we4 = 1;
    end else begin
      case (p)
        6'b100000: begin o.we3 = 1; o.s_inm = 2'b01; end
        6'b100001: o.s_inc = 0;
        6'b100010: o.s_inc = !zz;
        6'b100011: o.s_inc = zz;
        6'b100100: o.push = 1;
        6'b100101: begin o.pop = 1; o.s_pila = 1; end
        6'b100110: begin o.we3 = 1; o.s_inm = 2'b11; o.s_port = op[5:4]; end
        6'b100111: o.we5 = 1;
        6'b101000: begin o.we5 = 1; o.s_out = 1; end
        6'b101001: begin o.pop = 1; o.s_ret = 1; o.s_inc = 0; end
        6'b111000: begin o.we3 = 1; o.s_inm = 2'b10; end
        default: ;
      endcase
    end
    return o;
  endfunction

  // Channel that would be taken now, or -1.
  function automatic int pick();
    if (m_invec || !m_ie || m_active) return -1;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic out_t model_out();
    out_t o = nop();
    int   id;
    if (!reset) return o;
    id = pick();
    if (m_invec) begin
      o.s_inc = 0; o.s_vec = 1; o.vec_addr = m_vec;
    end else if (id >= 0) begin
      o.s_inc = 0; o.push = 1;
      o.irq_ack[id] = 1'b1;
      o.vec_addr = VB + PW'(id);
    end else begin
      o = decode_op(opcode, z);
    end
    o.int_active = m_active;
    return o;
  endfunction

  function automatic void model_clock();
    int       id  = pick();
    bit [N-1:0] rise = irq & ~m_prev;
    bit [5:0] p  = opcode[15:10];
    m_prev = irq;
    if (m_invec) begin
      m_invec = 0;
    end else if (id >= 0) begin
      m_pend[id] = 0; m_active = 1; m_ie = 0; m_invec = 1;
      m_vec = VB + PW'(id);
    end else if (p == 6'b101001) begin
      m_active = 0; m_ie = 1;
    end else if (p == 6'b101010) begin
      m_ie = opcode[0];
    end else if (p == 6'b101011) begin
      m_mask = opcode[N-1:0];
    end
    m_pend = m_pend | rise;
  endfunction

  // One cycle of stimulus: drive just after the edge, record expectation,
  // then advance the model on the next edge.
  task automatic step(input logic [15:0] op, input logic zz,
                      input logic [N-1:0] ir, input logic rs);
    opcode = op; z = zz; irq = ir; reset = rs;
    if (!rs) model_reset();
    #1;
    exp_q.push_back(model_out());
    @(posedge clk);
    if (reset) model_clock();
    #1;
  endtask

  // Monitor: compare once per cycle away from the active edge.
  always @(negedge clk) begin
    out_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d op=%h act=%h exp=%h", cyc, opcode, act, e);
      end
    end
  end

  localparam logic [15:0] ARITH = 16'h1234;
  localparam logic [15:0] RETI  = 16'hA400;
  localparam logic [15:0] EI    = 16'hA801;
  localparam logic [15:0] IMASK = 16'hAC00;

  initial begin
    logic [15:0] op;
    logic [N-1:0] ir;
    logic [5:0]  pf;
    int          r;
    opcode = '0; z = 0; irq = '0; reset = 0;
    model_reset();
    @(posedge clk); #1;

    // Reset held: outputs stay NOP whatever the opcode.
    step(ARITH, 0, '0, 0);
    step(16'h8000, 0, '0, 0);
    // Basic decode.
    step(16'h805A, 0, '0, 1);
    step(16'hB000, 0, '0, 1);
    step(16'h8800, 1, '0, 1);
    step(16'h8800, 0, '0, 1);
    step(16'h8C00, 1, '0, 1);
    step(16'h8C00, 0, '0, 1);
    step(16'h9830, 0, '0, 1);
    // EI, then a one-cycle pulse on irq[2] while arith opcodes flow.
    step(EI, 0, '0, 1);
    step(ARITH, 0, 4'b0100, 1);
    for (int i = 0; i < 4; i++) step(ARITH, 0, '0, 1);
    step(RETI, 0, '0, 1);
    step(ARITH, 0, '0, 1);
    // Two simultaneous edges: channel 1 first, channel 3 after RETI.
    step(ARITH, 0, 4'b1010, 1);
    for (int i = 0; i < 3; i++) step(ARITH, 0, '0, 1);
    step(RETI, 0, '0, 1);
    for (int i = 0; i < 3; i++) step(ARITH, 0, '0, 1);
    step(RETI, 0, '0, 1);
    // Masked request is retained, then taken once unmasked.
    step(IMASK, 0, '0, 1);
    step(ARITH, 0, 4'b0001, 1);
    for (int i = 0; i < 3; i++) step(ARITH, 0, '0, 1);
    step(IMASK | 16'h0001, 0, '0, 1);
    step(ARITH, 0, '0, 1);
    // Reset during the VEC cycle, then no take without a fresh edge.
    step(ARITH, 0, '0, 0);
    step(EI, 0, '0, 1);
    for (int i = 0; i < 3; i++) step(ARITH, 0, '0, 1);
    step(IMASK | 16'h000F, 0, 4'b0001, 1);
    for (int i = 0; i < 3; i++) step(ARITH, 0, '0, 1);
    step(RETI, 0, '0, 1);

    // Randomized traffic with a weighted instruction mix.
    ir = '0;
    for (int k = 0; k < 4000; k++) begin
      op = 16'($urandom);
      r  = int'($urandom_range(0, 19));
      case (r)
        0, 1, 2: pf = {1'b0, op[14:10]};
        3:  pf = 6'b100000;
        4:  pf = 6'b100001 + 6'($urandom_range(0, 7));
        5:  pf = 6'b101000;
        6:  pf = 6'b111000;
        7:  pf = 6'b111100 | 6'($urandom_range(0, 3));
        8, 9, 10: pf = 6'b101001;
        11, 12: pf = 6'b101010;
        13: pf = 6'b101011;
        14: pf = 6'b101100 + 6'($urandom_range(0, 11));
        default: pf = {1'b0, op[14:10]};
      endcase
      if (pf == 6'b101010 && $urandom_range(0, 3) != 0) op[0] = 1'b1;
      if (pf == 6'b101011 && $urandom_range(0, 2) != 0) op[3:0] = 4'hF;
      op[15:10] = pf;
      ir = ir ^ N'($urandom & $urandom & $urandom);
      step(op, 1'($urandom), ir, ($urandom_range(0, 199) != 0));
    end

    step(ARITH, 0, '0, 1);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d need=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
